// File: rtl/morse_symbol_assembler.sv
// Collects dot/dash elements from the keyed line into Morse symbol tokens and
// hands them to a consumer through a single valid/ready output register.
// state | meaning
// IDLE  | nothing in progress since the last token
// MARK  | line is keyed, mark length being counted
// GAP   | between elements of a symbol still being assembled
module morse_symbol_assembler (
  input  logic       clk,
  input  logic       rst,
  input  logic       in,
  input  logic       cb,
  input  logic       is,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [4:0] sym_bits,
  output logic [2:0] sym_len,
  output logic       word_sp,
  output logic       sym_ovf,
  output logic       mark_err,
  output logic       lost,
  output logic [1:0] state
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_MARK = 2'b01;
  localparam logic [1:0] ST_GAP  = 2'b10;

  logic [1:0] state_q;
  logic [1:0] state_nxt;
  logic [3:0] mark_cnt;
  logic [4:0] pend_bits;
  logic [2:0] pend_len;
  logic       pend_ovf;
  logic       pend_err;

  logic       mark_end;
  logic       elem_ok;
  logic       elem_dash;
  logic [4:0] nxt_bits;
  logic [2:0] nxt_len;
  logic       nxt_ovf;
  logic       nxt_err;
  logic       token_form;
  logic       token_load;
  logic       token_drop;

  assign state = state_q;

  // An element ending this cycle is folded in before deciding on a token, so a
  // boundary pulse on the closing cycle still captures it.
  always_comb begin
    mark_end  = (state_q == ST_MARK) && !in;
    elem_ok   = mark_end && (mark_cnt < 4'd8);
    elem_dash = (mark_cnt >= 4'd3);
    nxt_bits  = pend_bits;
    nxt_len   = pend_len;
    nxt_ovf   = pend_ovf;
    nxt_err   = pend_err;
    if (mark_end && !elem_ok)
      nxt_err = 1'b1;
    if (elem_ok) begin
      if (pend_len == 3'd5) begin
        nxt_ovf = 1'b1;
      end else begin
        nxt_bits = pend_bits | ({4'b0000, elem_dash} << pend_len);
        nxt_len  = pend_len + 3'd1;
      end
    end
    token_form = is || (cb && (nxt_len != 3'd0));
    token_load = token_form && (!out_valid || out_ready);
    token_drop = token_form && out_valid && !out_ready;
  end

  always_comb begin
    state_nxt = ST_IDLE;
    case (state_q)
      ST_IDLE: state_nxt = in ? ST_MARK : ST_IDLE;
      ST_MARK: state_nxt = in ? ST_MARK : ST_GAP;
      // A new mark starting takes priority so its first cycle is counted.
      ST_GAP:  state_nxt = in ? ST_MARK : (token_form ? ST_IDLE : ST_GAP);
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      mark_cnt  <= 4'd0;
      pend_bits <= 5'd0;
      pend_len  <= 3'd0;
      pend_ovf  <= 1'b0;
      pend_err  <= 1'b0;
      out_valid <= 1'b0;
      sym_bits  <= 5'd0;
      sym_len   <= 3'd0;
      word_sp   <= 1'b0;
      sym_ovf   <= 1'b0;
      mark_err  <= 1'b0;
      lost      <= 1'b0;
    end else begin
      state_q <= state_nxt;

      if (in) begin
        if (state_q == ST_MARK) begin
          if (mark_cnt != 4'd15)
            mark_cnt <= mark_cnt + 4'd1;
        end else if (state_q == ST_IDLE || state_q == ST_GAP) begin
          mark_cnt <= 4'd1;
        end
      end

      if (token_form) begin
        pend_bits <= 5'd0;
        pend_len  <= 3'd0;
        pend_ovf  <= 1'b0;
        pend_err  <= 1'b0;
      end else begin
        pend_bits <= nxt_bits;
        pend_len  <= nxt_len;
        pend_ovf  <= nxt_ovf;
        pend_err  <= nxt_err;
      end

      if (token_load) begin
        out_valid <= 1'b1;
        sym_bits  <= nxt_bits;
        sym_len   <= nxt_len;
        word_sp   <= is;
        sym_ovf   <= nxt_ovf;
        mark_err  <= nxt_err;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (token_drop)
        lost <= 1'b1;
    end
  end

endmodule

// File: tb/tb_morse_symbol_assembler.sv
// Bench for morse_symbol_assembler: table-driven and hand-written sequences
// plus random traffic, all checked against a run-length/queue model.
module tb_morse_symbol_assembler;

  logic       clk = 1'b0;
  logic       rst, line, cb, iws, rdy;
  logic       out_valid, word_sp, sym_ovf, mark_err, lost;
  logic [4:0] sym_bits;
  logic [2:0] sym_len;
  logic [1:0] state;

  int n_cmp = 0;
  int n_mis = 0;

  morse_symbol_assembler dut (
    .clk(clk), .rst(rst), .in(line), .cb(cb), .is(iws), .out_ready(rdy),
    .out_valid(out_valid), .sym_bits(sym_bits), .sym_len(sym_len),
    .word_sp(word_sp), .sym_ovf(sym_ovf), .mark_err(mark_err),
    .lost(lost), .state(state)
  );

  always #5 clk = ~clk;

  // Reference model: mark run length, pending element queue, output register.
  bit       m_in_mark;
  int       m_run;
  bit       m_pend[$];
  bit       m_perr, m_povf;
  bit       m_ov, m_ws, m_sovf, m_serr, m_lost;
  int       m_bits, m_slen;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit i_in, input bit i_cb, input bit i_is,
                            input bit i_rdy, input bit i_rst);
    bit ev, el, form;
    if (i_rst) begin
      m_in_mark = 0; m_run = 0; m_pend.delete(); m_perr = 0; m_povf = 0;
      m_ov = 0; m_ws = 0; m_sovf = 0; m_serr = 0; m_lost = 0;
      m_bits = 0; m_slen = 0;
      return;
    end
    ev = 0; el = 0;
    if (m_in_mark) begin
      if (i_in) m_run = (m_run < 15) ? m_run + 1 : 15;
      else begin
        m_in_mark = 0;
        if (m_run >= 8) m_perr = 1;
        else begin ev = 1; el = (m_run >= 3); end
      end
    end else if (i_in) begin
      m_in_mark = 1; m_run = 1;
    end
    if (ev) begin
      if (m_pend.size() == 5) m_povf = 1;
      else m_pend.push_back(el);
    end
    form = i_is || (i_cb && m_pend.size() > 0);
    if (form) begin
      if (m_ov && !i_rdy) m_lost = 1;
      else begin
        m_bits = 0;
        foreach (m_pend[k]) if (m_pend[k]) m_bits += (1 << k);
        m_slen = m_pend.size(); m_ws = i_is; m_sovf = m_povf; m_serr = m_perr;
        m_ov = 1;
      end
      m_pend.delete(); m_perr = 0; m_povf = 0;
    end else if (m_ov && i_rdy) begin
      m_ov = 0;
    end
  endtask

  task automatic cyc(input bit i_in, input bit i_cb, input bit i_is,
                     input bit i_rdy, input bit i_rst = 0);
    line = i_in; cb = i_cb; iws = i_is; rdy = i_rdy; rst = i_rst;
    @(posedge clk);
    model_step(i_in, i_cb, i_is, i_rdy, i_rst);
    #1;
    chk("out_valid", out_valid, m_ov);
    chk("lost", lost, m_lost);
    if (m_ov) begin
      chk("sym_bits", sym_bits, m_bits);
      chk("sym_len", sym_len, m_slen);
      chk("word_sp", word_sp, m_ws);
      chk("sym_ovf", sym_ovf, m_sovf);
      chk("mark_err", mark_err, m_serr);
    end
  endtask

  task automatic check_token(input string nm, input int v, input int b, input int l,
                             input int w, input int o, input int e);
    chk({nm, "_valid"}, out_valid, v);
    chk({nm, "_bits"}, sym_bits, b);
    chk({nm, "_len"}, sym_len, l);
    chk({nm, "_ws"}, word_sp, w);
    chk({nm, "_ovf"}, sym_ovf, o);
    chk({nm, "_err"}, mark_err, e);
  endtask

  typedef struct {
    bit       in, cb, is, rdy;
    bit       exp_valid;
    bit [4:0] exp_bits;
    bit [2:0] exp_len;
    bit       exp_ws;
    bit [1:0] exp_state;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int run_left;
    bit cur_in;

    // dot, dash, dot with one-cycle gaps, then a character boundary
    tbl[0] = '{1, 0, 0, 1, 0, 5'd0, 3'd0, 0, 2'b01};
    tbl[1] = '{0, 0, 0, 1, 0, 5'd0, 3'd0, 0, 2'b10};
    tbl[2] = '{1, 0, 0, 1, 0, 5'd0, 3'd0, 0, 2'b01};
    tbl[3] = '{1, 0, 0, 1, 0, 5'd0, 3'd0, 0, 2'b01};
    tbl[4] = '{1, 0, 0, 1, 0, 5'd0, 3'd0, 0, 2'b01};
    tbl[5] = '{0, 0, 0, 1, 0, 5'd0, 3'd0, 0, 2'b10};
    tbl[6] = '{1, 0, 0, 1, 0, 5'd0, 3'd0, 0, 2'b01};
    tbl[7] = '{0, 0, 0, 1, 0, 5'd0, 3'd0, 0, 2'b10};
    tbl[8] = '{0, 1, 0, 1, 1, 5'b00010, 3'd3, 0, 2'b00};
    tbl[9] = '{0, 0, 0, 1, 0, 5'd0, 3'd0, 0, 2'b00};

    line = 0; cb = 0; iws = 0; rdy = 0; rst = 1;
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    check_token("reset", 0, 0, 0, 0, 0, 0);
    chk("reset_lost", lost, 0);
    chk("reset_state", state, 0);

    foreach (tbl[i]) begin
      cyc(tbl[i].in, tbl[i].cb, tbl[i].is, tbl[i].rdy);
      chk("tbl_valid", out_valid, tbl[i].exp_valid);
      chk("tbl_state", state, tbl[i].exp_state);
      if (tbl[i].exp_valid) begin
        chk("tbl_bits", sym_bits, tbl[i].exp_bits);
        chk("tbl_len", sym_len, tbl[i].exp_len);
        chk("tbl_ws", word_sp, tbl[i].exp_ws);
      end
    end

    // six dots: the sixth is discarded as overflow
    for (int i = 0; i < 6; i++) begin cyc(1, 0, 0, 1); cyc(0, 0, 0, 1); end
    cyc(0, 1, 0, 1);
    check_token("ovf", 1, 0, 5, 0, 1, 0);

    // over-long mark dropped as an error, then a dot, then word space
    for (int i = 0; i < 10; i++) cyc(1, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(1, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 1, 1);
    check_token("err", 1, 0, 1, 1, 0, 1);

    cyc(0, 0, 1, 1);
    check_token("empty_ws", 1, 0, 0, 1, 0, 0);
    cyc(0, 1, 0, 1);
    chk("cb_empty_ignored", out_valid, 0);

    // dash closing on the same cycle as cb and is
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 1);
    cyc(0, 1, 1, 1);
    check_token("cb_is", 1, 1, 1, 1, 0, 0);
    cyc(0, 0, 0, 1);

    // consumer stalled: second token dropped, first held
    cyc(1, 0, 0, 0); cyc(0, 1, 0, 0);
    check_token("held_a", 1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    check_token("held_b", 1, 0, 1, 0, 0, 0);
    chk("lost_set", lost, 1);
    cyc(0, 0, 0, 1);
    chk("drop_after_ready", out_valid, 0);
    chk("lost_sticky", lost, 1);

    // mark in progress across cb stays with the next token
    cyc(1, 0, 0, 1); cyc(0, 0, 0, 1);
    cyc(1, 0, 0, 1); cyc(1, 1, 0, 1);
    check_token("split_a", 1, 0, 1, 0, 0, 0);
    chk("split_state", state, 1);
    cyc(1, 0, 0, 1); cyc(0, 1, 0, 1);
    check_token("split_b", 1, 1, 1, 0, 0, 0);

    // reset with token held and mark in progress
    cyc(1, 0, 0, 0); cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0, 1);
    check_token("rst_mid", 0, 0, 0, 0, 0, 0);
    chk("rst_mid_lost", lost, 0);
    chk("rst_mid_state", state, 0);
    cyc(0, 1, 0, 1);
    cyc(0, 1, 0, 1);
    chk("no_token_after_rst", out_valid, 0);
    cyc(1, 0, 0, 1);
    chk("first_mark_after_rst", state, 1);
    cyc(0, 0, 0, 1);

    // random traffic against the model
    run_left = 0; cur_in = 0;
    for (int n = 0; n < 4000; n++) begin
      bit r_cb, r_is, r_rdy, r_rst;
      if (run_left == 0) begin
        cur_in = ~cur_in;
        if (cur_in) run_left = ($urandom_range(0, 9) == 0) ? $urandom_range(8, 17)
                                                             : $urandom_range(1, 7);
        else        run_left = $urandom_range(1, 4);
      end
      run_left--;
      r_cb  = ($urandom_range(0, 4) == 0);
      r_is  = ($urandom_range(0, 24) == 0);
      r_rdy = ($urandom_range(0, 2) != 0);
      r_rst = ($urandom_range(0, 599) == 0);
      cyc(cur_in, r_cb, r_is, r_rdy, r_rst);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
